mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
Two-requester arbiter and access sequencer for the single shared memory port (ROM/RAM on the 16-bit address and 8-bit data bus). Requester 0 is the control unit's fetch/execute path. Requester 1 is the debug/display reader that feeds the segmented display. The block serialises accesses, drives the memory-side address, enable and write-enable for a configurable memory latency, and returns read data to the granted requester with a one-cycle done pulse.

Parameters:
ADDR_W, 16, address width of the requester and memory buses.
DATA_W, 8, data width.
MEM_LATENCY, 0, extra wait cycles after the ACCESS cycle before mem_rdata is sampled. Legal range 0..7, held in a 3-bit counter.
ARB_MODE, 0, arbitration policy. 0 = round-robin. 1 = fixed priority with requester 0 always winning.

Ports:
clk_in  input  1  system clock; all state changes on the rising edge
reset_n  input  1  asynchronous, active-low reset
req0  input  1  requester 0 access request; level signal, held until done0
we0  input  1  requester 0 write enable; 1 = write, 0 = read
addr0  input  ADDR_W  requester 0 address
wdata0  input  DATA_W  requester 0 write data
req1  input  1  requester 1 access request
we1  input  1  requester 1 write enable
addr1  input  ADDR_W  requester 1 address
wdata1  input  DATA_W  requester 1 write data
gnt0  output  1  requester 0 owns the memory port
gnt1  output  1  requester 1 owns the memory port
done0  output  1  one-cycle pulse: requester 0 transaction complete
done1  output  1  one-cycle pulse: requester 1 transaction complete
rdata  output  DATA_W  read data for the transaction completing this cycle; held until the next DONE
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_en  output  1  memory enable
mem_we  output  1  memory write strobe
mem_rdata  input  DATA_W  memory read data; combinational ROM is acceptable
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: async on reset_n=0. Every output goes to 0. State goes to IDLE, the wait counter to 0, and last_owner to 1, so requester 0 wins the first tie.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States are IDLE, ACCESS, WAIT and DONE.
- IDLE:
  - If any req is high on a clock edge, arbitrate and go to ACCESS.
  - Latch the winner's we, addr and wdata at that edge.
  - If no req is high, stay in IDLE.
- Arbitration, ARB_MODE=0:
  - Only one requester is requesting: that requester wins.
  - Both are requesting: the requester that is not last_owner wins.
  - last_owner is updated at the grant.
- Arbitration, ARB_MODE=1: req0 always wins when it is high. Requester 1 can starve; that is intended.
- ACCESS (exactly 1 cycle):
  - mem_en=1.
  - mem_addr and mem_wdata come from the latched request.
  - mem_we equals the latched we in this cycle only.
  - gnt of the winner =1.
  - Next state is WAIT if MEM_LATENCY>0, otherwise DONE.
- WAIT (MEM_LATENCY cycles):
  - mem_en stays 1, mem_addr stays held, mem_we=0.
  - The counter counts up. Leave for DONE when it reaches MEM_LATENCY-1.
- Read-data capture: mem_rdata is sampled into rdata at the edge that leaves the last ACCESS/WAIT cycle. Writes do not update rdata.
- DONE (1 cycle):
  - done of the owner =1 and gnt is still 1.
  - mem_en=0.
  - Next state is IDLE.
  - gnt is therefore high from ACCESS through DONE inclusive.
- Latency: from req sampled in IDLE to the done pulse is MEM_LATENCY+2 cycles. Back-to-back transaction period is MEM_LATENCY+3 cycles.
- Outside a transaction, mem_addr and mem_wdata hold their last values and mem_en=mem_we=0.
- req deasserted mid-transaction: ignored. The transaction completes and done still pulses.
- req held high through DONE: treated as a new request and re-arbitrated in the following IDLE cycle.
- Address and data inputs changing after the grant are ignored; only the latched values are used.
- Reset mid-transaction: immediate abort to the reset values. No done pulse is produced.
- gnt0 and gnt1 are never high simultaneously. done0 and done1 are never high simultaneously.

Test Plan:
- Reset: reset_n=0 during activity -> every output 0 immediately, before the next clock edge. After release with no requests -> busy=0 and IDLE held.
- Single read, MEM_LATENCY=0, ROM[0x0000]=0xA0: req0=1, addr0=0x0000 at T0 -> mem_en=1 with mem_addr=0x0000 at T1. At T2: done0=1, rdata=0xA0, gnt0=1. At T3: gnt0=0 and busy=0.
- Latency, MEM_LATENCY=2, ROM[0x0001]=0xFF: read from addr 0x0001 -> mem_en high for 3 cycles, done0 at T4, rdata=0xFF.
- Contention, ARB_MODE=0: req0 and req1 held high continuously with MEM_LATENCY=0 -> grants alternate 0,1,0,1 with period 3 cycles and done pulses alternate. With ARB_MODE=1 -> only done0 ever pulses.
- Write: req1=1, we1=1, addr1=0x0010, wdata1=0x5A -> mem_we=1 only in the ACCESS cycle with mem_wdata=0x5A, done1 pulses, and rdata is unchanged.
- Abort and release:
  - Drop req0 during WAIT -> done0 still pulses.
  - Assert reset_n=0 during WAIT -> no done pulse, all outputs 0.
  - After reset release, a pending req1 is granted first.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester arbiter and access sequencer for the
// shared memory port; every output comes straight from a flop.
module mem_bus_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int MEM_LATENCY = 0,
    parameter int ARB_MODE    = 0
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_en,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [2:0] LAT_LAST =
        (MEM_LATENCY > 0) ? 3'(MEM_LATENCY - 1) : 3'd0;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              last_owner_q, last_owner_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              busy_q, busy_d;
    logic              pick1;

    // Requester 1 wins when alone, or on a round-robin tie it did not win last.
    always_comb begin
        pick1 = req1 & (~req0 | ((ARB_MODE == 0) & ~last_owner_q));
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    owner_d      = pick1;
                    last_owner_d = pick1;
                    we_d         = pick1 ? we1 : we0;
                    addr_d       = pick1 ? addr1 : addr0;
                    wdata_d      = pick1 ? wdata1 : wdata0;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d   = 3'd0;
                state_d = (MEM_LATENCY > 0) ? S_WAIT : S_DONE;
            end
            S_WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered images of the state being entered.
    always_comb begin
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if ((state_q == S_ACCESS || state_q == S_WAIT) &&
            state_d == S_DONE && !we_q) begin
            rdata_d = mem_rdata;
        end
        if (state_d == S_ACCESS) begin
            mem_addr_d  = addr_d;
            mem_wdata_d = wdata_d;
        end
        mem_en_d = (state_d == S_ACCESS) || (state_d == S_WAIT);
        mem_we_d = (state_d == S_ACCESS) && we_d;
        gnt0_d   = (state_d != S_IDLE) && !owner_d;
        gnt1_d   = (state_d != S_IDLE) && owner_d;
        done0_d  = (state_d == S_DONE) && !owner_d;
        done1_d  = (state_d == S_DONE) && owner_d;
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            busy_q       <= busy_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;

endmodule
